// File: rtl/leve2_csr_unit.sv
// Machine/supervisor CSR file: registered read, checked RMW write, trap entry/return, counters.
// Latency: CSR_RD, CSR_ILL, REDIRECT and REDIRECT_PC are registered, one cycle after their inputs.
// Backpressure: none; every access, trap and return is accepted in the cycle it is presented.
`ifndef LEVE2_CSR_DEFS
`define LEVE2_CSR_DEFS
`define CSR_NONE  2'b00
`define CSR_SET   2'b01
`define CSR_CLEAR 2'b10
`define CSR_WRITE 2'b11
`define MODE_U    2'b00
`define MODE_S    2'b01
`define MODE_M    2'b11
`endif

module leve2_csr_unit #(
    parameter int              XLEN     = 64,
    parameter int              NUM_HPM  = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic [11:0]        CSR_RA,
    output logic [XLEN-1:0]    CSR_RD,
    input  logic [1:0]         CSR_WCMD,
    input  logic [11:0]        CSR_WA,
    input  logic [XLEN-1:0]    CSR_WD,
    output logic               CSR_ILL,
    input  logic               RETIRE,
    input  logic [NUM_HPM-1:0] HPM_EV,
    input  logic               TRAP,
    input  logic [XLEN-1:0]    TRAP_CAUSE,
    input  logic [XLEN-1:0]    TRAP_EPC,
    input  logic [XLEN-1:0]    TRAP_TVAL,
    input  logic               MRET,
    input  logic               SRET,
    output logic               REDIRECT,
    output logic [XLEN-1:0]    REDIRECT_PC,
    output logic [1:0]         MODE
);
    localparam int              HN           = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [XLEN-1:0] SSTATUS_MASK = XLEN'(32'h000C_6122);
    localparam logic [31:0]     CINH_MASK    = 32'h5 | 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);

    logic            sie, mie, spie, mpie, spp, sum, mxr, tsr;
    logic [1:0]      mpp, fs;
    logic [XLEN-1:0] stvec, sscratch, sepc, scause, stval, satp;
    logic [XLEN-1:0] medeleg, mtvec, mscratch, mepc, mcause, mtval;
    logic [31:0]     mcountinhibit;
    logic [XLEN-1:0] mcycle, minstret;
    logic [XLEN-1:0] hpm [HN];

    logic [XLEN-1:0] mstatus_val, rd_nxt, wr_old, wr_new, t_cause, tvec_sel, trap_pc;
    logic [63:0]     deleg_ext;
    logic            acc_bad, mret_bad, sret_bad, take_trap, do_mret, do_sret, delegate;
    logic            busy, wr_en, ill_nxt;

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[1]     = sie;
        mstatus_val[3]     = mie;
        mstatus_val[5]     = spie;
        mstatus_val[7]     = mpie;
        mstatus_val[8]     = spp;
        mstatus_val[12:11] = mpp;
        mstatus_val[14:13] = fs;
        mstatus_val[18]    = sum;
        mstatus_val[19]    = mxr;
        mstatus_val[22]    = tsr;
    end

    function automatic logic [XLEN-1:0] csr_value(input logic [11:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        case (a)
            12'h100: v = mstatus_val & SSTATUS_MASK;
            12'h105: v = stvec;
            12'h140: v = sscratch;
            12'h141: v = sepc;
            12'h142: v = scause;
            12'h143: v = stval;
            12'h180: v = satp;
            12'h300: v = mstatus_val;
            12'h302: v = medeleg;
            12'h305: v = mtvec;
            12'h320: v = XLEN'(mcountinhibit);
            12'h340: v = mscratch;
            12'h341: v = mepc;
            12'h342: v = mcause;
            12'h343: v = mtval;
            12'hb00, 12'hc00: v = mcycle;
            12'hb02, 12'hc02: v = minstret;
            default: begin
                for (int i = 0; i < NUM_HPM; i++) begin
                    if (a == 12'(12'hb03 + i) || a == 12'(12'hc03 + i))
                        v = hpm[i];
                end
            end
        endcase
        return v;
    endfunction

    function automatic logic [XLEN-1:0] tvec_warl(input logic [XLEN-1:0] v);
        return {v[XLEN-1:2], (v[1:0] > 2'd1) ? 2'b00 : v[1:0]};
    endfunction

    always_comb begin
        rd_nxt = csr_value(CSR_RA);
        wr_old = csr_value(CSR_WA);
        case (CSR_WCMD)
            `CSR_SET:   wr_new = wr_old | CSR_WD;
            `CSR_CLEAR: wr_new = wr_old & ~CSR_WD;
            default:    wr_new = CSR_WD;
        endcase
        acc_bad   = (CSR_WCMD != `CSR_NONE) && ((MODE < CSR_WA[9:8]) || (CSR_WA[11:10] == 2'b11));
        // Returns from an insufficient privilege level become illegal-instruction traps.
        mret_bad  = MRET && (MODE != `MODE_M);
        sret_bad  = SRET && ((MODE == `MODE_U) || ((MODE == `MODE_S) && tsr));
        take_trap = TRAP || mret_bad || sret_bad;
        do_mret   = MRET && !take_trap;
        do_sret   = SRET && !take_trap;
        busy      = TRAP || MRET || SRET;
        wr_en     = (CSR_WCMD != `CSR_NONE) && !acc_bad && !busy;
        ill_nxt   = acc_bad && !busy;
        t_cause   = TRAP ? TRAP_CAUSE : XLEN'(2);
        deleg_ext = 64'(medeleg);
        delegate  = (MODE != `MODE_M) && !t_cause[XLEN-1] && deleg_ext[t_cause[5:0]];
        tvec_sel  = delegate ? stvec : mtvec;
        trap_pc   = {tvec_sel[XLEN-1:2], 2'b00};
        if (tvec_sel[1:0] == 2'b01 && t_cause[XLEN-1])
            trap_pc = trap_pc + XLEN'({t_cause[5:0], 2'b00});
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            MODE          <= `MODE_M;
            CSR_RD        <= '0;
            CSR_ILL       <= 1'b0;
            REDIRECT      <= 1'b0;
            REDIRECT_PC   <= '0;
            {sie, mie, spie, mpie, spp, sum, mxr, tsr} <= '0;
            mpp           <= `MODE_M;
            fs            <= 2'b00;
            stvec         <= RESET_PC;
            mtvec         <= RESET_PC;
            {sscratch, sepc, scause, stval, satp} <= '0;
            {medeleg, mscratch, mepc, mcause, mtval} <= '0;
            mcountinhibit <= '0;
            mcycle        <= '0;
            minstret      <= '0;
            for (int i = 0; i < HN; i++) hpm[i] <= '0;
        end else begin
            CSR_RD   <= rd_nxt;
            CSR_ILL  <= ill_nxt;
            REDIRECT <= 1'b0;
            if (!mcountinhibit[0]) mcycle <= mcycle + 1'b1;
            if (!mcountinhibit[2] && RETIRE) minstret <= minstret + 1'b1;
            for (int i = 0; i < NUM_HPM; i++)
                if (!mcountinhibit[3+i] && HPM_EV[i]) hpm[i] <= hpm[i] + 1'b1;

            if (take_trap) begin
                REDIRECT    <= 1'b1;
                REDIRECT_PC <= trap_pc;
                if (delegate) begin
                    sepc   <= TRAP_EPC;
                    scause <= t_cause;
                    stval  <= TRAP_TVAL;
                    spp    <= MODE[0];
                    spie   <= sie;
                    sie    <= 1'b0;
                    MODE   <= `MODE_S;
                end else begin
                    mepc   <= TRAP_EPC;
                    mcause <= t_cause;
                    mtval  <= TRAP_TVAL;
                    mpp    <= MODE;
                    mpie   <= mie;
                    mie    <= 1'b0;
                    MODE   <= `MODE_M;
                end
            end else if (do_mret) begin
                REDIRECT    <= 1'b1;
                REDIRECT_PC <= mepc;
                MODE        <= mpp;
                mie         <= mpie;
                mpie        <= 1'b1;
                mpp         <= `MODE_U;
            end else if (do_sret) begin
                REDIRECT    <= 1'b1;
                REDIRECT_PC <= sepc;
                MODE        <= {1'b0, spp};
                sie         <= spie;
                spie        <= 1'b1;
                spp         <= 1'b0;
            end else if (wr_en) begin
                // Counter writes here override the increments above.
                case (CSR_WA)
                    12'h100: begin
                        sie  <= wr_new[1];
                        spie <= wr_new[5];
                        spp  <= wr_new[8];
                        fs   <= wr_new[14:13];
                        sum  <= wr_new[18];
                        mxr  <= wr_new[19];
                    end
                    12'h300: begin
                        sie  <= wr_new[1];
                        mie  <= wr_new[3];
                        spie <= wr_new[5];
                        mpie <= wr_new[7];
                        spp  <= wr_new[8];
                        mpp  <= (wr_new[12:11] == 2'b10) ? `MODE_U : wr_new[12:11];
                        fs   <= wr_new[14:13];
                        sum  <= wr_new[18];
                        mxr  <= wr_new[19];
                        tsr  <= wr_new[22];
                    end
                    12'h105: stvec         <= tvec_warl(wr_new);
                    12'h140: sscratch      <= wr_new;
                    12'h141: sepc          <= {wr_new[XLEN-1:1], 1'b0};
                    12'h142: scause        <= wr_new;
                    12'h143: stval         <= wr_new;
                    12'h180: satp          <= wr_new;
                    12'h302: medeleg       <= wr_new;
                    12'h305: mtvec         <= tvec_warl(wr_new);
                    12'h320: mcountinhibit <= wr_new[31:0] & CINH_MASK;
                    12'h340: mscratch      <= wr_new;
                    12'h341: mepc          <= {wr_new[XLEN-1:1], 1'b0};
                    12'h342: mcause        <= wr_new;
                    12'h343: mtval         <= wr_new;
                    12'hb00: mcycle        <= wr_new;
                    12'hb02: minstret      <= wr_new;
                    default: begin
                        for (int i = 0; i < NUM_HPM; i++)
                            if (CSR_WA == 12'(12'hb03 + i)) hpm[i] <= wr_new;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_leve2_csr_unit.sv
// Scoreboard bench for leve2_csr_unit: directed stimulus queues expectations, a negedge monitor checks them.
module tb_leve2_csr_unit;
    localparam logic [1:0] C_NONE = 2'd0, C_SET = 2'd1, C_WR = 2'd3;
    localparam int K_RD = 0, K_MODE = 1, K_ILL = 2, K_RED = 3, K_RPC = 4;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [11:0] CSR_RA = '0, CSR_WA = '0;
    logic [1:0]  CSR_WCMD = C_NONE;
    logic [63:0] CSR_WD = '0, TRAP_CAUSE = '0, TRAP_EPC = '0, TRAP_TVAL = '0;
    logic        RETIRE = 1'b0, TRAP = 1'b0, MRET = 1'b0, SRET = 1'b0;
    logic [3:0]  HPM_EV = '0;
    logic [63:0] CSR_RD, REDIRECT_PC;
    logic        CSR_ILL, REDIRECT;
    logic [1:0]  MODE;

    leve2_csr_unit #(.XLEN(64), .NUM_HPM(4), .RESET_PC(64'h100)) dut (
        .CLK(CLK), .RSTn(RSTn), .CSR_RA(CSR_RA), .CSR_RD(CSR_RD), .CSR_WCMD(CSR_WCMD),
        .CSR_WA(CSR_WA), .CSR_WD(CSR_WD), .CSR_ILL(CSR_ILL), .RETIRE(RETIRE), .HPM_EV(HPM_EV),
        .TRAP(TRAP), .TRAP_CAUSE(TRAP_CAUSE), .TRAP_EPC(TRAP_EPC), .TRAP_TVAL(TRAP_TVAL),
        .MRET(MRET), .SRET(SRET), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .MODE(MODE)
    );

    always #5 CLK = ~CLK;

    typedef struct { int due; int kind; logic [63:0] val; string name; } exp_t;
    exp_t eq[$], rq[$], iq[$];
    exp_t mon_e, fin_e;
    logic [63:0] mon_act;
    int cyc = 0, total = 0, bad = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [63:0] pick(input int k);
        case (k)
            K_RD:    return CSR_RD;
            K_MODE:  return 64'(MODE);
            K_ILL:   return 64'(CSR_ILL);
            K_RED:   return 64'(REDIRECT);
            default: return REDIRECT_PC;
        endcase
    endfunction

    always @(negedge CLK) begin
        while (eq.size() > 0 && eq[0].due <= cyc) begin
            mon_e   = eq.pop_front();
            mon_act = pick(mon_e.kind);
            total++;
            if (mon_e.due != cyc || mon_act !== mon_e.val) begin
                bad++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", mon_e.name, mon_act, mon_e.val, cyc);
            end
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            mon_e = rq.pop_front();
            total++;
            if (REDIRECT !== 1'b1 || REDIRECT_PC !== mon_e.val) begin
                bad++;
                $display("FAIL %s: got redirect=%b pc=0x%0h expected redirect=1 pc=0x%0h", mon_e.name, REDIRECT, REDIRECT_PC, mon_e.val);
            end
        end else if (REDIRECT !== 1'b0) begin
            total++; bad++;
            $display("FAIL unexpected_redirect: got %b expected 0 (cycle %0d)", REDIRECT, cyc);
        end
        if (iq.size() > 0 && iq[0].due == cyc) begin
            mon_e = iq.pop_front();
            total++;
            if (CSR_ILL !== 1'b1) begin
                bad++;
                $display("FAIL %s: got csr_ill=%b expected 1", mon_e.name, CSR_ILL);
            end
        end else if (CSR_ILL !== 1'b0) begin
            total++; bad++;
            $display("FAIL unexpected_ill: got %b expected 0 (cycle %0d)", CSR_ILL, cyc);
        end
    end

    task automatic push_exp(input int due, input int kind, input logic [63:0] v, input string n);
        exp_t e;
        int pos;
        e.due = due; e.kind = kind; e.val = v; e.name = n;
        pos = eq.size();
        while (pos > 0 && eq[pos-1].due > due) pos--;
        eq.insert(pos, e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        CSR_WCMD = C_NONE; CSR_WA = '0; CSR_WD = '0; RETIRE = 1'b0; HPM_EV = '0;
        TRAP = 1'b0; TRAP_CAUSE = '0; TRAP_EPC = '0; TRAP_TVAL = '0; MRET = 1'b0; SRET = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [63:0] v, input string n);
        CSR_RA = a;
        push_exp(cyc + 1, K_RD, v, n);
    endtask
    task automatic rdt(input logic [11:0] a, input logic [63:0] v, input string n);
        rd(a, v, n); tick();
    endtask
    task automatic wr(input logic [1:0] c, input logic [11:0] a, input logic [63:0] d);
        CSR_WCMD = c; CSR_WA = a; CSR_WD = d;
    endtask
    task automatic wrt(input logic [1:0] c, input logic [11:0] a, input logic [63:0] d);
        wr(c, a, d); tick();
    endtask
    task automatic exp_mode(input logic [1:0] m, input string n);
        push_exp(cyc + 1, K_MODE, 64'(m), n);
    endtask
    task automatic exp_redir(input logic [63:0] pc, input string n);
        exp_t e;
        e.due = cyc + 1; e.kind = K_RPC; e.val = pc; e.name = n;
        rq.push_back(e);
    endtask
    task automatic exp_ill(input string n);
        exp_t e;
        e.due = cyc + 1; e.kind = K_ILL; e.val = 64'd1; e.name = n;
        iq.push_back(e);
    endtask
    task automatic trap(input logic [63:0] cause, input logic [63:0] epc, input logic [63:0] tval);
        TRAP = 1'b1; TRAP_CAUSE = cause; TRAP_EPC = epc; TRAP_TVAL = tval;
    endtask

    initial begin
        #1;
        push_exp(cyc + 1, K_RD, 64'h0, "rst_rd");
        push_exp(cyc + 1, K_MODE, 64'd3, "rst_mode");
        push_exp(cyc + 1, K_ILL, 64'd0, "rst_ill");
        push_exp(cyc + 1, K_RED, 64'd0, "rst_redirect");
        push_exp(cyc + 1, K_RPC, 64'h0, "rst_redirect_pc");
        tick(); tick();
        RSTn = 1'b1;
        tick();

        rdt(12'h300, 64'h1800, "mstatus_reset");
        rd(12'h305, 64'h100, "mtvec_no_forward"); wrt(C_WR, 12'h305, 64'h8000_0001);
        rdt(12'h305, 64'h8000_0001, "mtvec_write");
        wr(C_WR, 12'hc00, 64'h0); exp_ill("m_write_ro_cycle"); tick();

        wrt(C_WR, 12'h320, 64'h1);
        wrt(C_WR, 12'hb00, 64'h50);
        for (int i = 0; i < 10; i++) begin
            RETIRE = 1'b1;
            if (i == 9) rd(12'hb00, 64'h50, "mcycle_inhibited");
            tick();
        end
        rdt(12'hb02, 64'd10, "minstret_plus10");
        rdt(12'hc00, 64'h50, "cycle_alias");
        rdt(12'hc02, 64'd10, "instret_alias");

        wrt(C_WR, 12'hb00, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'hb00, 64'hFFFF_FFFF_FFFF_FFFF, "mcycle_ones_a"); wrt(C_WR, 12'h320, 64'h0);
        rdt(12'hb00, 64'hFFFF_FFFF_FFFF_FFFF, "mcycle_ones_b");
        rdt(12'hb00, 64'h0, "mcycle_wrap");
        wrt(C_WR, 12'hb00, 64'd5);
        rdt(12'hb00, 64'd5, "mcycle_write_wins");
        for (int i = 0; i < 3; i++) begin HPM_EV = 4'b0010; tick(); end
        rdt(12'hb04, 64'd3, "hpm4_events");
        rdt(12'hc04, 64'd3, "hpm4_alias");
        rdt(12'hb03, 64'd0, "hpm3_idle");
        wrt(C_SET, 12'hb05, 64'h10);
        rdt(12'hb05, 64'h10, "hpm5_set");

        wrt(C_WR, 12'h302, 64'h100);
        wrt(C_WR, 12'h105, 64'h4000);
        wrt(C_WR, 12'h341, 64'h2000);
        wrt(C_WR, 12'h300, 64'h2);
        rdt(12'h300, 64'h2, "mstatus_sie_mppu");
        MRET = 1'b1; exp_redir(64'h2000, "mret_to_u"); exp_mode(2'd0, "mode_u"); tick();
        wr(C_WR, 12'h300, 64'hFFFF); exp_ill("u_write_mstatus"); tick();
        rdt(12'h300, 64'h82, "mstatus_unchanged");
        wr(C_SET, 12'h300, 64'h0); exp_ill("u_set_zero"); tick();
        wr(C_WR, 12'hc00, 64'h0); exp_ill("u_write_ro"); tick();

        trap(64'd8, 64'h1000, 64'h55); wr(C_WR, 12'h141, 64'hDEAD);
        exp_redir(64'h4000, "deleg_trap_stvec"); exp_mode(2'd1, "mode_s_deleg"); tick();
        rdt(12'h141, 64'h1000, "sepc_trap");
        rdt(12'h142, 64'd8, "scause_trap");
        rdt(12'h143, 64'h55, "stval_trap");
        rdt(12'h100, 64'h20, "sstatus_trap");
        wrt(C_WR, 12'h140, 64'hABC);
        rdt(12'h140, 64'hABC, "sscratch_s");
        wr(C_WR, 12'h300, 64'h0); exp_ill("s_write_mstatus"); tick();
        SRET = 1'b1; exp_redir(64'h1000, "sret_sepc"); exp_mode(2'd0, "mode_u_sret"); tick();
        rdt(12'h100, 64'h22, "sstatus_sret");
        SRET = 1'b1; TRAP_EPC = 64'h3000;
        exp_redir(64'h8000_0000, "sret_u_illegal"); exp_mode(2'd3, "mode_m_ill"); tick();
        rdt(12'h342, 64'd2, "mcause_ill_sret");
        rdt(12'h341, 64'h3000, "mepc_ill_sret");

        wrt(C_SET, 12'h300, 64'h8);
        trap(64'd2, 64'h5004, 64'h0); exp_redir(64'h8000_0000, "m_trap"); exp_mode(2'd3, "mode_m_trap"); tick();
        rdt(12'h300, 64'h18A2, "mstatus_m_trap");
        MRET = 1'b1; exp_redir(64'h5004, "mret_mepc"); exp_mode(2'd3, "mode_mret_prev"); tick();
        rdt(12'h300, 64'hAA, "mstatus_mret");
        trap(64'h8000_0000_0000_0007, 64'h6000, 64'h0);
        exp_redir(64'h8000_001C, "vectored_irq"); tick();
        rdt(12'h342, 64'h8000_0000_0000_0007, "mcause_irq");

        wrt(C_WR, 12'h341, 64'h7001);
        rdt(12'h341, 64'h7000, "mepc_warl");
        wrt(C_WR, 12'h105, 64'h4003);
        rdt(12'h105, 64'h4000, "stvec_warl");
        wrt(C_WR, 12'h100, 64'hFFFF_FFFF_FFFF_FFFF);
        rdt(12'h100, 64'hC6122, "sstatus_mask");

        wrt(C_WR, 12'h300, 64'h800);
        MRET = 1'b1; exp_redir(64'h7000, "mret_to_s"); exp_mode(2'd1, "mode_s_mret"); tick();
        trap(64'd8, 64'h8000, 64'h0);
        tick();
        RSTn = 1'b0;
        push_exp(cyc, K_RED, 64'd0, "reset_cancels_redirect");
        push_exp(cyc, K_RPC, 64'h0, "reset_redirect_pc");
        push_exp(cyc, K_MODE, 64'd3, "reset_mode");
        tick(); tick();
        RSTn = 1'b1;
        tick();
        rdt(12'h300, 64'h1800, "mstatus_after_reset");
        rdt(12'h105, 64'h100, "stvec_after_reset");
        rdt(12'h341, 64'h0, "mepc_after_reset");
        rdt(12'h140, 64'h0, "sscratch_after_reset");

        repeat (3) tick();
        while (eq.size() > 0) begin
            fin_e = eq.pop_front(); total++; bad++;
            $display("FAIL %s: got nothing expected 0x%0h", fin_e.name, fin_e.val);
        end
        while (rq.size() > 0) begin
            fin_e = rq.pop_front(); total++; bad++;
            $display("FAIL %s: got no redirect expected pc 0x%0h", fin_e.name, fin_e.val);
        end
        while (iq.size() > 0) begin
            fin_e = iq.pop_front(); total++; bad++;
            $display("FAIL %s: got no csr_ill expected 1", fin_e.name);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
